// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
//   Multi-cycle control sequencer sitting in front of the ALU. It decodes the
//   instruction held in the instruction register and steps it through
//   FETCH / DECODE / EXEC / MEM / WB, driving the ALU controls and the
//   datapath write enables. It also keeps a count of retired instructions.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   op, funct       instr[31:26] and instr[5:0], stable after FETCH
//   zero            ALU zero flag, used by beq in BRANCH
//   carry           ALU signed-overflow flag, used by addi in EXEC_I
//   less            ALU less flag, consumed by the writeback mux (not the FSM)
//   aluctr          00 add, 01 sub, 10 or
//   alusrc          0 register B, 1 extended immediate
//   addi            enables ALU overflow detection
//   ir_we, pc_we    instruction register / PC write enables
//   pc_src          00 PC+4, 01 branch target, 10 jump target
//   reg_we, reg_dst register-file write enable, 0 = rt / 1 = rd
//   wb_sel          00 ALU result, 01 memory data, 10 {31'b0, less}
//   mem_we          data-memory write enable
//   ovf, illegal    one-cycle pulses: addi overflow, undecodable instruction
//   halted          high while parked in HALT
//   instr_cnt       retired-instruction counter, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int         CNT_W   = 16,
  parameter logic [5:0] HALT_OP = 6'h3f
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             carry,
  input  logic             less,
  output logic [1:0]       aluctr,
  output logic             alusrc,
  output logic             addi,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic [1:0]       wb_sel,
  output logic             mem_we,
  output logic             ovf,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I, S_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    K_ADDU, K_SUBU, K_SLT, K_ORI, K_ADDI, K_LW, K_SW, K_BEQ, K_J,
    K_HALT, K_ILL
  } kind_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_SLT   = 6'b101010;

  state_t state, state_nxt;
  kind_t  dec_kind, kind;
  logic   retire;

  // The less flag only steers the writeback mux in the datapath; the
  // sequencer never branches on it, so it is sunk here on purpose.
  logic   less_unused;
  assign less_unused = less;

  // Instruction classifier. Used as-is in DECODE to pick the next state and
  // captured into 'kind' so later states do not depend on op/funct again.
  always_comb begin
    dec_kind = K_ILL;
    case (op)
      OP_R: begin
        case (funct)
          F_ADDU:  dec_kind = K_ADDU;
          F_SUBU:  dec_kind = K_SUBU;
          F_SLT:   dec_kind = K_SLT;
          default: dec_kind = K_ILL;
        endcase
      end
      OP_ORI:  dec_kind = K_ORI;
      OP_ADDI: dec_kind = K_ADDI;
      OP_LW:   dec_kind = K_LW;
      OP_SW:   dec_kind = K_SW;
      OP_BEQ:  dec_kind = K_BEQ;
      OP_J:    dec_kind = K_J;
      default: dec_kind = (op == HALT_OP) ? K_HALT : K_ILL;
    endcase
  end

  // State register, the latched instruction class and the retire counter.
  // Reset drops back to FETCH; an instruction in flight is simply abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      kind      <= K_ILL;
      instr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE)
        kind <= dec_kind;
      if (retire)
        instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state and output decode. Outputs follow the registered state, with
  // three exceptions that must react in the same cycle: pc_we in BRANCH
  // follows zero, ovf in EXEC_I follows carry, and illegal in DECODE follows
  // the decode result. While reset is asserted every output is forced low so
  // nothing downstream sees FETCH enables during reset.
  always_comb begin
    state_nxt = state;
    aluctr    = 2'b00;
    alusrc    = 1'b0;
    addi      = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'b00;
    reg_we    = 1'b0;
    reg_dst   = 1'b0;
    wb_sel    = 2'b00;
    mem_we    = 1'b0;
    ovf       = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    retire    = 1'b0;

    case (state)
      S_FETCH: begin
        ir_we     = 1'b1;
        pc_we     = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (dec_kind)
          K_ADDU, K_SUBU, K_SLT: state_nxt = S_EXEC_R;
          K_ORI, K_ADDI:         state_nxt = S_EXEC_I;
          K_LW, K_SW:            state_nxt = S_ADDR;
          K_BEQ:                 state_nxt = S_BRANCH;
          K_J:                   state_nxt = S_JUMP;
          K_HALT:                state_nxt = S_HALT;
          default: begin
            illegal   = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        aluctr    = (kind == K_ADDU) ? 2'b00 : 2'b01;
        state_nxt = S_WB_R;
      end
      S_EXEC_I: begin
        alusrc = 1'b1;
        if (kind == K_ORI) begin
          aluctr    = 2'b10;
          state_nxt = S_WB_I;
        end else begin
          addi = 1'b1;
          if (carry) begin
            ovf       = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB_I;
          end
        end
      end
      S_WB_R: begin
        // ALU operands stay put so the result is still valid at writeback.
        aluctr    = (kind == K_ADDU) ? 2'b00 : 2'b01;
        reg_we    = 1'b1;
        reg_dst   = 1'b1;
        wb_sel    = (kind == K_SLT) ? 2'b10 : 2'b00;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_WB_I: begin
        // Immediate operand held for the same reason as WB_R.
        alusrc    = 1'b1;
        aluctr    = (kind == K_ORI) ? 2'b10 : 2'b00;
        reg_we    = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ADDR: begin
        alusrc    = 1'b1;
        state_nxt = (kind == K_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        alusrc    = 1'b1;
        state_nxt = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_we    = 1'b1;
        wb_sel    = 2'b01;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEM_WR: begin
        // Address kept on the ALU output for the duration of the write.
        alusrc    = 1'b1;
        mem_we    = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        aluctr    = 2'b01;
        pc_src    = 2'b01;
        pc_we     = zero;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pc_src    = 2'b10;
        pc_we     = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted    = 1'b1;
        state_nxt = S_HALT;
      end
      default: state_nxt = S_FETCH;
    endcase

    if (rst) begin
      aluctr  = 2'b00;
      alusrc  = 1'b0;
      addi    = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      pc_src  = 2'b00;
      reg_we  = 1'b0;
      reg_dst = 1'b0;
      wb_sel  = 2'b00;
      mem_we  = 1'b0;
      ovf     = 1'b0;
      illegal = 1'b0;
      halted  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
//   Directed bench for mc_ctrl_fsm built with a 4-bit retire counter so the
//   wrap can be reached quickly. The stimulus side issues one instruction at
//   a time and queues the hand-worked output bundle expected in every cycle;
//   the monitor side pops one entry per clock and compares it on the falling
//   edge.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic [1:0] aluctr;
    logic       alusrc;
    logic       addi;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic [1:0] wb_sel;
    logic       mem_we;
    logic       ovf;
    logic       illegal;
    logic       halted;
    logic [3:0] cnt;
  } outs_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'h3f;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_SLT   = 6'b101010;

  logic       clk;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero, carry, less;
  logic [1:0] aluctr, pc_src, wb_sel;
  logic       alusrc, addi, ir_we, pc_we, reg_we, reg_dst, mem_we;
  logic       ovf, illegal, halted;
  logic [3:0] instr_cnt;

  outs_t      act;
  outs_t      exp_q[$];
  outs_t      msk_q[$];
  string      nm_q[$];
  logic [3:0] exp_cnt;
  int         vectors;
  int         miscompares;

  mc_ctrl_fsm #(.CNT_W(4), .HALT_OP(6'h3f)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct),
    .zero(zero), .carry(carry), .less(less),
    .aluctr(aluctr), .alusrc(alusrc), .addi(addi), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .mem_we(mem_we), .ovf(ovf), .illegal(illegal),
    .halted(halted), .instr_cnt(instr_cnt)
  );

  assign act = {aluctr, alusrc, addi, ir_we, pc_we, pc_src, reg_we, reg_dst,
                wb_sel, mem_we, ovf, illegal, halted, instr_cnt};

  // 10-unit clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one sampled bundle against its queued expectation.
  task automatic checkOutput(input outs_t e, input outs_t m, input string n);
    vectors++;
    if (((act ^ e) & m) != '0) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h (care mask %h)", n, act, e, m);
    end
  endtask

  // Monitor: one expectation per clock, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0)
        checkOutput(exp_q.pop_front(), msk_q.pop_front(), nm_q.pop_front());
    end
  end

  task automatic push(input outs_t e, input outs_t m, input string n);
    exp_q.push_back(e);
    msk_q.push_back(m);
    nm_q.push_back(n);
  endtask

  // Move to the start of the next cycle, after the state has updated.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic outs_t base();
    outs_t b;
    b     = '0;
    b.cnt = exp_cnt;
    return b;
  endfunction

  task automatic applyReset(input int n);
    outs_t full;
    full = '1;
    for (int i = 0; i < n; i++) begin
      step();
      rst     = 1'b1;
      exp_cnt = 4'd0;
      push(base(), full, "reset");
    end
  endtask

  // Issue one instruction starting in FETCH and queue the expected output
  // bundle for each cycle it occupies. abort_wb stops after EXEC_R so the
  // caller can hit reset in the cycle that would have been WB_R.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                               input logic zf, input logic cf, input logic lf,
                               input bit abort_wb);
    outs_t e, full, held;
    full        = '1;
    held        = '1;
    held.alusrc = 1'b0;
    held.aluctr = 2'b00;

    step();
    rst = 1'b0; op = o; funct = f; zero = zf; carry = cf; less = lf;
    e = base(); e.ir_we = 1'b1; e.pc_we = 1'b1;
    push(e, full, "fetch");

    step();
    e = base();
    if (o == OP_R && (f == F_ADDU || f == F_SUBU || f == F_SLT)) begin
      push(e, full, "decode_r");
      step(); e = base(); e.aluctr = (f == F_ADDU) ? 2'b00 : 2'b01;
      push(e, full, "exec_r");
      if (abort_wb) return;
      step(); e.reg_we = 1'b1; e.reg_dst = 1'b1;
      e.wb_sel = (f == F_SLT) ? 2'b10 : 2'b00;
      push(e, full, "wb_r");
      exp_cnt = exp_cnt + 4'd1;
    end else if (o == OP_ORI || o == OP_ADDI) begin
      push(e, full, "decode_i");
      step(); e = base(); e.alusrc = 1'b1;
      if (o == OP_ORI) begin
        e.aluctr = 2'b10;
      end else begin
        e.addi = 1'b1;
        e.ovf  = cf;
      end
      push(e, full, "exec_i");
      if (o == OP_ADDI && cf) return;
      step(); e = base(); e.reg_we = 1'b1;
      push(e, held, "wb_i");
      exp_cnt = exp_cnt + 4'd1;
    end else if (o == OP_LW || o == OP_SW) begin
      push(e, full, "decode_mem");
      step(); e = base(); e.alusrc = 1'b1;
      push(e, full, "addr");
      if (o == OP_LW) begin
        step(); push(e, full, "mem_rd");
        step(); e = base(); e.reg_we = 1'b1; e.wb_sel = 2'b01;
        push(e, full, "wb_mem");
      end else begin
        step(); e = base(); e.mem_we = 1'b1;
        push(e, held, "mem_wr");
      end
      exp_cnt = exp_cnt + 4'd1;
    end else if (o == OP_BEQ) begin
      push(e, full, "decode_beq");
      step(); e = base(); e.aluctr = 2'b01; e.pc_src = 2'b01; e.pc_we = zf;
      push(e, full, "branch");
      exp_cnt = exp_cnt + 4'd1;
    end else if (o == OP_J) begin
      push(e, full, "decode_j");
      step(); e = base(); e.pc_src = 2'b10; e.pc_we = 1'b1;
      push(e, full, "jump");
      exp_cnt = exp_cnt + 4'd1;
    end else if (o == OP_HALT) begin
      push(e, full, "decode_halt");
      for (int i = 0; i < 4; i++) begin
        step(); e = base(); e.halted = 1'b1;
        push(e, full, "halt");
      end
    end else begin
      e.illegal = 1'b1;
      push(e, full, "decode_illegal");
    end
  endtask

  // Stimulus: directed instruction sequence.
  initial begin
    rst = 1'b1; op = '0; funct = '0; zero = 1'b0; carry = 1'b0; less = 1'b0;
    exp_cnt = 4'd0; vectors = 0; miscompares = 0;

    applyReset(3);
    applyStimulus(OP_R,    F_SUBU, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(OP_R,    F_ADDU, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_R,    F_SLT,  1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(OP_ORI,  6'h15,  1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(OP_ADDI, 6'h00,  1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_ADDI, 6'h00,  1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(OP_BEQ,  6'h00,  1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_BEQ,  6'h00,  1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(OP_J,    6'h00,  1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_LW,   6'h00,  1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_SW,   6'h00,  1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(6'h17,   6'h00,  1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_R,    6'h00,  1'b0, 1'b0, 1'b0, 1'b0);

    // Abort an addu where WB_R would start; the counter is non-zero here.
    applyStimulus(OP_R,    F_ADDU, 1'b0, 1'b0, 1'b0, 1'b1);
    applyReset(3);

    // Sixteen retirements bring the 4-bit counter back round to zero.
    for (int i = 0; i < 16; i++)
      applyStimulus(OP_R, F_ADDU, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(OP_HALT, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyReset(2);
    applyStimulus(OP_J,    6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_R,    F_SUBU, 1'b0, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain, but never wait more than a few cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so a stuck run still ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish expected finish before limit");
    $fatal(1, "[TB] time limit expired");
  end

endmodule
